// File: rtl/seq_detect_controller.sv
// Run-time programmable serial pattern detector with a config/start/abort controller.
// Optional build macro NON_OVERLAP_EN: clear history after each match (non-overlapping detection).
module seq_detect_controller #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [W-1:0]             cfg_pattern,
    input  logic [$clog2(W+1)-1:0]   cfg_len,
    input  logic [CW-1:0]            cfg_limit,
    output logic                     cfg_err,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     a_valid,
    input  logic                     a,
    output logic                     a_ready,
    output logic                     detected,
    output logic [CW-1:0]            match_count,
    output logic                     done,
    output logic                     busy
);

    localparam int unsigned LW = $clog2(W+1);
    localparam int unsigned WP = W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    pattern_q, pattern_d;
    logic [LW-1:0]   len_q, len_d;
    logic [CW-1:0]   limit_q, limit_d;
    logic [W-2:0]    hist_q, hist_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   match_count_q, match_count_d;
    logic            detected_q, detected_d;
    logic            cfg_err_q, cfg_err_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            a_ready_q, a_ready_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            cfg_hs;
    logic            len_ok;
    logic [W-1:0]    hist_sh;
    logic [LW-1:0]   cnt_inc;
    logic [WP-1:0]   mask_w;
    logic [W-1:0]    mask;
    logic            match_hit;
    logic [CW-1:0]   count_inc;

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        limit_d       = limit_q;
        hist_d        = hist_q;
        cnt_d         = cnt_q;
        match_count_d = match_count_q;
        detected_d    = 1'b0;
        cfg_err_d     = 1'b0;

        cfg_hs    = cfg_valid & cfg_ready_q;
        len_ok    = (cfg_len != LW'(0)) && (cfg_len <= LW'(W));
        hist_sh   = {hist_q, a};
        cnt_inc   = (cnt_q == LW'(W)) ? cnt_q : cnt_q + LW'(1);
        // mask has the low len_q bits set; computed one bit wider so len_q == W works
        mask_w    = (WP'(1) << len_q) - WP'(1);
        mask      = mask_w[W-1:0];
        match_hit = (((hist_sh ^ pattern_q) & mask) == '0) && (cnt_inc >= len_q);
        count_inc = (match_count_q == '1) ? match_count_q : match_count_q + CW'(1);

        unique case (state_q)
            S_IDLE, S_READY: begin
                if (cfg_hs) begin
                    if (len_ok) begin
                        pattern_d = cfg_pattern;
                        len_d     = cfg_len;
                        limit_d   = cfg_limit;
                        state_d   = S_READY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (start && (state_q == S_READY)) begin
                    hist_d        = '0;
                    cnt_d         = '0;
                    match_count_d = '0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_READY;
                end else if (a_valid) begin
                    hist_d = hist_sh[W-2:0];
                    cnt_d  = cnt_inc;
                    if (match_hit) begin
                        detected_d    = 1'b1;
                        match_count_d = count_inc;
`ifdef NON_OVERLAP_EN
                        hist_d        = '0;
                        cnt_d         = '0;
`endif
                        if ((limit_q != '0) && (count_inc == limit_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_READY;
                end else if (start) begin
                    hist_d        = '0;
                    cnt_d         = '0;
                    match_count_d = '0;
                    state_d       = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_READY);
        a_ready_d   = (state_d == S_RUN);
        busy_d      = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pattern_q     <= '0;
            len_q         <= '0;
            limit_q       <= '0;
            hist_q        <= '0;
            cnt_q         <= '0;
            match_count_q <= '0;
            detected_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            cfg_ready_q   <= 1'b1;
            a_ready_q     <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            limit_q       <= limit_d;
            hist_q        <= hist_d;
            cnt_q         <= cnt_d;
            match_count_q <= match_count_d;
            detected_q    <= detected_d;
            cfg_err_q     <= cfg_err_d;
            cfg_ready_q   <= cfg_ready_d;
            a_ready_q     <= a_ready_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign a_ready     = a_ready_q;
    assign detected    = detected_q;
    assign match_count = match_count_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: doc/seq_detect_controller.md
Name: seq_detect_controller

Overview:
Run-time programmable serial pattern detector with a scheduling controller. A host loads a pattern of up to W bits and a match limit over a valid/ready config handshake. The host then starts a detection run, and the block consumes a serial bitstream under a valid/ready handshake. It counts matches and stops accepting bits once the limit is reached. It replaces fixed hard-coded sequence-detector FSMs when the pattern must change without resynthesis.

Parameters:
W, 8, maximum pattern length in bits (W >= 2)
CW, 8, width of match counter and match limit

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  config word valid
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
cfg_pattern  in  W  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
cfg_len  in  $clog2(W+1)  pattern length, legal range 1..W
cfg_limit  in  CW  matches before the run ends; 0 = unlimited
cfg_err  out  1  one-cycle pulse: illegal config rejected
start  in  1  pulse: begin run
abort  in  1  pulse: end run, keep config
a_valid  in  1  serial bit valid
a  in  1  serial data bit
a_ready  out  1  block accepts bit when a_valid & a_ready
detected  out  1  one-cycle match pulse (registered)
match_count  out  CW  matches in current run, saturating at all-ones
done  out  1  limit reached
busy  out  1  state == RUN

Behaviour:
- Interface: one clock domain (clk); rst is synchronous, active-high.
- States:
  - IDLE: no valid config.
  - READY: configured, waiting for start.
  - RUN: consuming bits.
  - DONE: limit reached.
- Reset (any state, incl. mid-run): state = IDLE; pattern, len, limit, history, bit counter and match_count all cleared to 0; detected = 0, cfg_err = 0, done = 0, busy = 0, a_ready = 0, cfg_ready = 1.
- Output decode:
  - cfg_ready = (state == IDLE) | (state == READY)
  - a_ready = (state == RUN)
  - done = (state == DONE)
  - busy = (state == RUN)
- Config handshake:
  - Legal cfg_len: latch pattern, len, limit; go to READY.
  - cfg_len == 0 or cfg_len > W: nothing latched, state unchanged, cfg_err pulses the next cycle.
  - Config in RUN or DONE is not accepted.
- start:
  - In READY or DONE: clear history, bit counter and match_count; go to RUN.
  - In IDLE or RUN: ignored.
  - start together with a cfg handshake in READY: config wins, start ignored.
- Bit accept (RUN, a_valid & a_ready):
  - hist <= {hist[W-2:0], a}.
  - bit counter increments, saturating at W.
  - a_valid low: no shift, no count change.
- Match: on an accepted bit, let h' be the post-shift history and mask the low cfg_len bits set.
  - match = ((h' & mask) == (pattern & mask)) & (bit counter incl. this bit >= cfg_len).
  - detected = 1 in the cycle after the accepting edge, otherwise 0.
  - match_count increments on the same edge, saturating.
- Overlapping matches are counted by default.
- Limit: if cfg_limit != 0 and the incremented count equals cfg_limit, next state is DONE.
  - detected still pulses.
  - a_ready drops on the same edge, so no further bits are accepted.
- abort:
  - In RUN or DONE: go to READY, keep config and match_count.
  - abort has priority over a simultaneous accepted bit: the bit is dropped and no match is counted.
  - In IDLE or READY: ignored.
- Latency: bit accept to detected = 1 cycle; config accept to READY = 1 cycle; start to a_ready = 1 cycle.

Optional Feature:
NON_OVERLAP_EN:
- Defined: after a match, history and bit counter are cleared on the same edge, so the next match needs cfg_len fresh bits (non-overlapping detection).
- Undefined: history is kept after a match, so overlapping matches are counted.
- Port list is identical in both builds.

Test Plan:
- Overlapping 6-bit match:
  - Stimulus: cfg 6'b110011, len 6, limit 0; start; stream 1,1,0,0,1,1,0,0,1,1 with a_valid = 1.
  - Response: detected pulses after bits 6 and 10; match_count = 2; state stays RUN.
- Limit stop:
  - Stimulus: cfg 4'b1010, len 4, limit 2; stream 1,0,1,0,1,0,1.
  - Response: detected after bits 4 and 6; done = 1 and a_ready = 0 from the cycle after bit 6; bit 7 not accepted; match_count = 2.
- Illegal config:
  - Stimulus: cfg_len = 0, then cfg_len = W+1.
  - Response: cfg_err pulses each time; state remains IDLE; cfg_ready = 1; start ignored (busy stays 0).
- Valid gaps:
  - Stimulus: pattern 1010 with a_valid low for 3 cycles between each bit.
  - Response: exactly one detected pulse, one cycle after the fourth accepted bit.
- abort and reset:
  - Stimulus: abort in the same cycle as the completing bit.
  - Response: no detected pulse, state READY, match_count unchanged.
  - Stimulus: rst mid-RUN.
  - Response: IDLE, match_count = 0, cfg_ready = 1, a_ready = 0.
- NON_OVERLAP_EN:
  - Stimulus: pattern 1010, len 4, stream 1,0,1,0,1,0.
  - Response: match_count = 1 with the macro defined; 2 without it.
